// File: rtl/fsm_stim_sequencer_if.sv
// Host-side handshake bundle for fsm_stim_sequencer.
// master: start/pattern/loop out, busy/done/resp in; slave: the reverse.
interface fsm_stim_sequencer_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] pattern;
  logic         loop;
  logic         busy;
  logic         done;
  logic [N-1:0] resp;

  modport master (
    output start, pattern, loop,
    input  busy, done, resp
  );

  modport slave (
    input  start, pattern, loop,
    output busy, done, resp
  );
endinterface

// File: rtl/fsm_stim_sequencer.sv
// Shifts an N-bit pattern LSB first onto x_out and captures z_in into resp.
// Ports: clk, rst_n (async, low), h (host bundle), z_in, x_out. Macro: SEQ_LOOP_EN.
module fsm_stim_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fsm_stim_sequencer_if.slave  h,
  input  logic                 z_in,
  output logic                 x_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [N-1:0]     pat_q, pat_d;
  logic [N-1:0]     resp, resp_d;
  logic [N-1:0]     sh;
  logic             x_q, x_d;

  assign cnt_inc = cnt + CNT_W'(1);
  assign sh      = pat_q >> cnt_inc;

  // x is registered: its next value is the bit the next run cycle applies.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pat_d   = pat_q;
    resp_d  = resp;
    x_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (h.start) begin
          pat_d   = h.pattern;
          cnt_d   = '0;
          resp_d  = '0;
          x_d     = h.pattern[0];
          state_d = RUN;
        end
      end
      RUN: begin
        resp_d = resp | (N'(z_in) << cnt);
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          x_d   = sh[0];
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SEQ_LOOP_EN
        if (h.loop) begin
          cnt_d   = '0;
          resp_d  = '0;
          x_d     = pat_q[0];
          state_d = RUN;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pat_q <= '0;
      resp  <= '0;
      x_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pat_q <= pat_d;
      resp  <= resp_d;
      x_q   <= x_d;
    end
  end

  assign x_out  = x_q;
  assign h.busy = (state == RUN);
  assign h.done = (state == DONE);
  assign h.resp = resp;

endmodule
